// File: rtl/rv_pkg.sv
// Shared core constants: default register-file geometry, address-width
// derivation and the hard-wired x0 address.
package rv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int X0_ADDR  = 0;

    function automatic int rv_aw(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    localparam int AW_DEF = rv_aw(NREG_DEF);

    // Where a read port's data comes from in a given cycle.
    typedef enum logic [1:0] {
        SRC_STORED = 2'd0,
        SRC_PORT_A = 2'd1,
        SRC_PORT_B = 2'd2
    } rd_src_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of read ports, the two write ports, load issue and busy status
// shared between the register file and its pipeline client.
interface regfile_mp_if
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int NREAD = 2
);
    localparam int AW = rv_aw(NREG);

    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;

    logic                  wa_en;
    logic [AW-1:0]         wa_addr;
    logic [XLEN-1:0]       wa_data;

    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [XLEN-1:0]       wb_data;

    logic                  iss_en;
    logic [AW-1:0]         iss_addr;

    logic [AW:0]           busy_cnt;

    modport master (
        output rd_addr,
        output wa_en, wa_addr, wa_data,
        output wb_en, wb_addr, wb_data,
        output iss_en, iss_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr,
        input  wa_en, wa_addr, wa_data,
        input  wb_en, wb_addr, wb_data,
        input  iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register "load pending" bits with a registered population count and
// per-read-port busy lookup.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter  int NREG  = NREG_DEF,
    parameter  int NREAD = 2,
    localparam int AW    = rv_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                wb_en_i,
    input  logic [AW-1:0]       wb_addr_i,
    input  logic [NREAD*AW-1:0] rd_addr_i,
    output logic [NREAD-1:0]    rd_busy_o,
    output logic [AW:0]         busy_cnt_o
);
    localparam int            CW = AW + 1;
    localparam logic [AW-1:0] X0 = AW'(X0_ADDR);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            set_req, clr_req;
    logic            cnt_inc, cnt_dec;
    logic [AW-1:0]   rd_idx [NREAD];

    assign set_req = iss_en_i && (iss_addr_i != X0);
    assign clr_req = wb_en_i  && (wb_addr_i  != X0);

    // A clear and a set on the same register leave it busy, so the count
    // only moves on a genuine transition of a bit.
    always_comb begin
        busy_d = busy_q;
        if (clr_req) busy_d[wb_addr_i]  = 1'b0;
        if (set_req) busy_d[iss_addr_i] = 1'b1;
        cnt_inc = set_req && !busy_q[iss_addr_i];
        cnt_dec = clr_req && busy_q[wb_addr_i] &&
                  !(set_req && (iss_addr_i == wb_addr_i));
        cnt_d   = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_idx
        assign rd_idx[p] = rd_addr_i[p*AW +: AW];
    end

    // A same-cycle writeback releases the reader early unless a new load
    // re-claims the register in that same cycle.
    always_comb begin
        rd_busy_o = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (!rst && (rd_idx[p] != X0)) begin
                rd_busy_o[p] = busy_q[rd_idx[p]] &&
                               !(clr_req && (wb_addr_i == rd_idx[p]) &&
                                 !(set_req && (iss_addr_i == rd_idx[p])));
            end
        end
    end

    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with two write ports, same-cycle write
// bypass, hard-wired x0 and load-pending tracking.
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int NREAD = 2
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);
    localparam int            AW = rv_aw(NREG);
    localparam logic [AW-1:0] X0 = AW'(X0_ADDR);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wa_we, wb_we;
    logic [AW-1:0]   rd_idx [NREAD];
    rd_src_e         rd_src [NREAD];

    assign wa_we = bus.wa_en && (bus.wa_addr != X0);
    assign wb_we = bus.wb_en && (bus.wb_addr != X0);

    // Port B is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wa_we) regs_d[bus.wa_addr] = bus.wa_data;
        if (wb_we) regs_d[bus.wb_addr] = bus.wb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_idx
        assign rd_idx[p] = bus.rd_addr[p*AW +: AW];
    end

    always_comb begin
        for (int p = 0; p < NREAD; p++) begin
            if (wb_we && (bus.wb_addr == rd_idx[p])) begin
                rd_src[p] = SRC_PORT_B;
            end else if (wa_we && (bus.wa_addr == rd_idx[p])) begin
                rd_src[p] = SRC_PORT_A;
            end else begin
                rd_src[p] = SRC_STORED;
            end
        end
    end

    // Held at zero during reset so pending write data cannot leak through.
    always_comb begin
        bus.rd_data = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (!rst && (rd_idx[p] != X0)) begin
                unique case (rd_src[p])
                    SRC_PORT_B: bus.rd_data[p*XLEN +: XLEN] = bus.wb_data;
                    SRC_PORT_A: bus.rd_data[p*XLEN +: XLEN] = bus.wa_data;
                    default:    bus.rd_data[p*XLEN +: XLEN] = regs_q[rd_idx[p]];
                endcase
            end
        end
    end

    regfile_scoreboard #(
        .NREG  (NREG),
        .NREAD (NREAD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .iss_en_i   (bus.iss_en),
        .iss_addr_i (bus.iss_addr),
        .wb_en_i    (bus.wb_en),
        .wb_addr_i  (bus.wb_addr),
        .rd_addr_i  (bus.rd_addr),
        .rd_busy_o  (bus.rd_busy),
        .busy_cnt_o (bus.busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp: one vector per cycle, expected
// read-port view queued at drive time and checked on the falling edge.
module tb_regfile_mp;
    import rv_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    typedef struct {
        logic            wa_en;
        logic [AW-1:0]   wa_addr;
        logic [XLEN-1:0] wa_data;
        logic            wb_en;
        logic [AW-1:0]   wb_addr;
        logic [XLEN-1:0] wb_data;
        logic            iss_en;
        logic [AW-1:0]   iss_addr;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
    } stim_t;

    typedef struct {
        string           name;
        logic [XLEN-1:0] d0;
        logic [XLEN-1:0] d1;
        logic [1:0]      busy;
        logic [AW:0]     cnt;
    } exp_t;

    exp_t expQ[$];
    int   vectorsApplied = 0;
    int   miscompares    = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic stim_t vec(input int waE, input int waA, input logic [XLEN-1:0] waD,
                                  input int wbE, input int wbA, input logic [XLEN-1:0] wbD,
                                  input int issE, input int issA, input int r0, input int r1);
        stim_t s;
        s.wa_en    = (waE != 0);
        s.wa_addr  = AW'(waA);
        s.wa_data  = waD;
        s.wb_en    = (wbE != 0);
        s.wb_addr  = AW'(wbA);
        s.wb_data  = wbD;
        s.iss_en   = (issE != 0);
        s.iss_addr = AW'(issA);
        s.ra0      = AW'(r0);
        s.ra1      = AW'(r1);
        return s;
    endfunction

    function automatic stim_t rdOnly(input int r0, input int r1);
        return vec(0, 0, '0, 0, 0, '0, 0, 0, r0, r1);
    endfunction

    task automatic driveInputs(input stim_t s);
        bus.wa_en    = s.wa_en;
        bus.wa_addr  = s.wa_addr;
        bus.wa_data  = s.wa_data;
        bus.wb_en    = s.wb_en;
        bus.wb_addr  = s.wb_addr;
        bus.wb_data  = s.wb_data;
        bus.iss_en   = s.iss_en;
        bus.iss_addr = s.iss_addr;
        bus.rd_addr  = {s.ra1, s.ra0};
    endtask

    task automatic applyStimulus(input string name, input stim_t s,
                                 input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                                 input int busy, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        driveInputs(s);
        e.name = name;
        e.d0   = d0;
        e.d1   = d1;
        e.busy = 2'(busy);
        e.cnt  = (AW+1)'(cnt);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [XLEN-1:0] a0, a1;
        a0 = bus.rd_data[XLEN-1:0];
        a1 = bus.rd_data[2*XLEN-1:XLEN];
        vectorsApplied++;
        if (a0 !== e.d0 || a1 !== e.d1 || bus.rd_busy !== e.busy || bus.busy_cnt !== e.cnt) begin
            miscompares++;
            $display("[TB] FAIL %s: got rd0=%h rd1=%h busy=%b cnt=%0d, want rd0=%h rd1=%h busy=%b cnt=%0d",
                     e.name, a0, a1, bus.rd_busy, bus.busy_cnt, e.d0, e.d1, e.busy, e.cnt);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        driveInputs(rdOnly(0, 0));
        #1 rst = 1'b1;

        applyStimulus("reset_hold", vec(1, 6, 32'h66666666, 1, 8, 32'h88888888, 1, 6, 6, 8),
                      32'h0, 32'h0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        driveInputs(rdOnly(0, 0));

        applyStimulus("wa_bypass", vec(1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0, 5, 5),
                      32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        applyStimulus("wa_stored", rdOnly(5, 6), 32'hDEADBEEF, 32'h0, 0, 0);
        applyStimulus("ab_bypass", vec(1, 7, 32'h1, 1, 7, 32'h2, 0, 0, 7, 5),
                      32'h2, 32'hDEADBEEF, 0, 0);
        applyStimulus("ab_stored", rdOnly(7, 0), 32'h2, 32'h0, 0, 0);
        applyStimulus("x0_write", vec(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0),
                      32'h0, 32'h0, 0, 0);
        applyStimulus("x0_stored", rdOnly(0, 0), 32'h0, 32'h0, 0, 0);

        applyStimulus("iss3", vec(0, 0, '0, 0, 0, '0, 1, 3, 3, 9), 32'h0, 32'h0, 0, 0);
        applyStimulus("iss9", vec(0, 0, '0, 0, 0, '0, 1, 9, 3, 9), 32'h0, 32'h0, 1, 1);
        applyStimulus("busy2", rdOnly(3, 9), 32'h0, 32'h0, 3, 2);
        applyStimulus("wb_iss3", vec(0, 0, '0, 1, 3, 32'h55, 1, 3, 3, 9), 32'h55, 32'h0, 3, 2);
        applyStimulus("wb9", vec(0, 0, '0, 1, 9, 32'h99, 0, 0, 3, 9), 32'h55, 32'h99, 1, 2);
        applyStimulus("cnt1", rdOnly(3, 9), 32'h55, 32'h99, 1, 1);
        applyStimulus("reiss3", vec(0, 0, '0, 0, 0, '0, 1, 3, 3, 3), 32'h55, 32'h55, 3, 1);
        applyStimulus("reiss3_cnt", rdOnly(3, 3), 32'h55, 32'h55, 3, 1);
        applyStimulus("wb3", vec(0, 0, '0, 1, 3, 32'hAB, 0, 0, 3, 9), 32'hAB, 32'h99, 0, 1);
        applyStimulus("cnt0", rdOnly(3, 9), 32'hAB, 32'h99, 0, 0);
        applyStimulus("wb_nobusy", vec(0, 0, '0, 1, 12, 32'h12, 0, 0, 12, 0), 32'h12, 32'h0, 0, 0);
        applyStimulus("wb_nobusy_cnt", rdOnly(12, 7), 32'h12, 32'h2, 0, 0);

        for (int i = 1; i < NREG; i++) begin
            applyStimulus($sformatf("fill_x%0d", i),
                          vec(1, i, 32'hA5000000 + i, 0, 0, '0, 0, 0, i, 0),
                          32'hA5000000 + i, 32'h0, 0, 0);
        end
        applyStimulus("iss20", vec(0, 0, '0, 0, 0, '0, 1, 20, 31, 1),
                      32'hA500001F, 32'hA5000001, 0, 0);
        applyStimulus("pre_reset", rdOnly(20, 5), 32'hA5000014, 32'hA5000005, 1, 1);

        applyStimulus("reset_mid", vec(1, 10, 32'hCAFEF00D, 1, 11, 32'hCAFE1111, 1, 21, 10, 20),
                      32'h0, 32'h0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        driveInputs(vec(1, 10, 32'h77, 0, 0, '0, 0, 0, 0, 0));

        applyStimulus("first_write", rdOnly(10, 20), 32'h77, 32'h0, 0, 0);
        applyStimulus("post_reset2", rdOnly(11, 31), 32'h0, 32'h0, 0, 0);
        applyStimulus("post_reset3", rdOnly(1, 5), 32'h0, 32'h0, 0, 0);

        @(posedge clk);
        #1 driveInputs(rdOnly(0, 0));
        for (int k = 0; k < 20 && expQ.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d vectors still pending, want 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
